// File: rtl/cdb_pkg.sv
// Shared common-data-bus definitions used by the FUs, reservation stations and broadcast queue.
// A CDB entry is {tag, data} with the tag in the MSBs.
package cdb_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int TAG_WIDTH  = 7;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } cdb_entry_t;

  // Round-robin successor of idx among n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr (wrapping) wins.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] rr_ptr,
  input  logic                 enable,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  int j;

  // Scan farthest-first so the nearest requester after rr_ptr overwrites the rest.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    j         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % N;
      if (enable && req[j]) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/broadcast_queue.sv
// Collects FU results round-robin into a FIFO and presents the head on the CDB,
// one enqueue and one dequeue per cycle.
module broadcast_queue #(
  parameter int DATA_WIDTH = cdb_pkg::DATA_WIDTH,
  parameter int TAG_WIDTH  = cdb_pkg::TAG_WIDTH,
  parameter int NUM_FU     = 4,
  parameter int DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_FU-1:0]            done_in,
  input  logic [NUM_FU*DATA_WIDTH-1:0] result_in,
  input  logic [NUM_FU*TAG_WIDTH-1:0]  tag_in,
  output logic [NUM_FU-1:0]            queued,
  input  logic                         cdb_stall,
  output logic                         cdb_valid,
  output logic [TAG_WIDTH-1:0]         cdb_tag,
  output logic [DATA_WIDTH-1:0]        cdb_data,
  output logic                         full,
  output logic [$clog2(DEPTH):0]       count
);

  import cdb_pkg::*;

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int IDX_W = $clog2(NUM_FU);
  localparam int EW    = TAG_WIDTH + DATA_WIDTH;

  logic [NUM_FU-1:0] pending;
  logic [NUM_FU-1:0] grant;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [EW-1:0]     mem [DEPTH];
  logic              deq;
  logic              enq_ok;
  logic              grant_any;

  // Pointer MSB is the wrap bit, so full and empty are distinguishable.
  assign count     = wr_ptr - rd_ptr;
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign cdb_valid = (count != '0);
  assign deq       = cdb_valid && !cdb_stall;
  assign enq_ok    = !full || deq;
  assign grant_any = |grant;

  assign {cdb_tag, cdb_data} = mem[rd_ptr[AW-1:0]];

  rr_arbiter #(.N(NUM_FU)) u_arb (
    .req       (pending),
    .rr_ptr    (rr_ptr),
    .enable    (enq_ok),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= '0;
      queued  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rr_ptr  <= '0;
    end else begin
      pending <= (pending | done_in) & ~grant;
      queued  <= grant;
      if (grant_any) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        rr_ptr <= IDX_W'(rr_next(int'(grant_idx), NUM_FU));
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage carries no reset; only valid entries are ever observed.
  always_ff @(posedge clk) begin
    if (grant_any) begin
      mem[wr_ptr[AW-1:0]] <= {tag_in[grant_idx*TAG_WIDTH +: TAG_WIDTH],
                              result_in[grant_idx*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

endmodule

// File: tb/tb_broadcast_queue.sv
// Self-checking bench for broadcast_queue: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_broadcast_queue;

  localparam int NF    = 4;
  localparam int DW    = 32;
  localparam int TW    = 7;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NF-1:0]     done_in = '0;
  logic [NF*DW-1:0]  result_in = '0;
  logic [NF*TW-1:0]  tag_in = '0;
  logic [NF-1:0]     queued;
  logic              cdb_stall = 1'b0;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_data;
  logic              full;
  logic [3:0]        count;

  broadcast_queue #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .NUM_FU(NF), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .done_in   (done_in),
    .result_in (result_in),
    .tag_in    (tag_in),
    .queued    (queued),
    .cdb_stall (cdb_stall),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .full      (full),
    .count     (count)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: pending flags, round-robin pointer and an ordered queue of entries.
  logic [NF-1:0]  m_pend = '0;
  int             m_rr = 0;
  logic [38:0]    m_q[$];
  logic [NF-1:0]  m_queued = '0;
  logic [NF-1:0]  busy = '0;
  int             next_tag = 0;
  int             issued = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
    tag_in[i*TW +: TW]    = t;
    result_in[i*DW +: DW] = d;
    done_in[i]            = 1'b1;
    busy[i]               = 1'b1;
  endtask

  task automatic random_issue(input int limit, input int prob);
    for (int i = 0; i < NF; i++) begin
      if (!busy[i] && issued < limit && $urandom_range(99) < prob) begin
        issue(i, TW'(next_tag), $urandom);
        next_tag++;
        issued++;
      end
    end
  endtask

  task automatic cycle();
    logic [NF-1:0] g;
    logic          deq_m;
    logic          enq_m;
    int            w;
    logic [38:0]   head;
    g = '0;
    w = -1;
    if (!rst) begin
      m_pend   = '0;
      m_rr     = 0;
      m_q.delete();
      m_queued = '0;
    end else begin
      deq_m = (m_q.size() != 0) && !cdb_stall;
      enq_m = (m_q.size() < DEPTH) || deq_m;
      for (int k = 0; k < NF; k++)
        if (w < 0 && m_pend[(m_rr + k) % NF]) w = (m_rr + k) % NF;
      if (deq_m) void'(m_q.pop_front());
      if (enq_m && w >= 0) begin
        m_q.push_back({tag_in[w*TW +: TW], result_in[w*DW +: DW]});
        g[w] = 1'b1;
        m_rr = (w + 1) % NF;
      end
      m_pend   = (m_pend | done_in) & ~g;
      m_queued = g;
    end
    @(posedge clk);
    #1;
    chk("cdb_valid", 64'(cdb_valid), 64'(m_q.size() != 0));
    chk("count", 64'(count), 64'(m_q.size()));
    chk("full", 64'(full), 64'(m_q.size() == DEPTH));
    chk("queued", 64'(queued), 64'(m_queued));
    if (m_q.size() != 0) begin
      head = m_q[0];
      chk("cdb_tag", 64'(cdb_tag), 64'(head[38:32]));
      chk("cdb_data", 64'(cdb_data), 64'(head[31:0]));
    end
    busy    = busy & ~m_queued;
    done_in = '0;
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    cycle();
    cycle();
    chk("reset_valid", 64'(cdb_valid), 64'(0));
    chk("reset_count", 64'(count), 64'(0));
    rst = 1'b1;

    // Single result from FU 2
    issue(2, 7'h15, 32'h0000_00F0);
    cycle();
    chk("single_c1_queued", 64'(queued), 64'(0));
    chk("single_c1_valid", 64'(cdb_valid), 64'(0));
    cycle();
    chk("single_c2_queued", 64'(queued), 64'(4'b0100));
    chk("single_c2_valid", 64'(cdb_valid), 64'(1));
    chk("single_c2_tag", 64'(cdb_tag), 64'(7'h15));
    chk("single_c2_data", 64'(cdb_data), 64'(32'h0000_00F0));
    cycle();
    chk("single_c3_count", 64'(count), 64'(0));
    chk("single_c3_queued", 64'(queued), 64'(0));

    // Bring rr_ptr back to 0 via FU 3, then all four at once
    issue(3, 7'h7F, 32'h1234_5678);
    for (int n = 0; n < 3; n++) cycle();
    for (int i = 0; i < NF; i++) issue(i, TW'(i + 1), 32'hA000_0000 + 32'(i));
    cycle();
    for (int k = 0; k < NF; k++) begin
      cycle();
      chk("rr_queued", 64'(queued), 64'(4'b0001 << k));
      chk("rr_tag", 64'(cdb_tag), 64'(k + 1));
    end
    cycle();
    issue(0, 7'h05, 32'h5);
    issue(1, 7'h06, 32'h6);
    cycle();
    cycle();
    chk("rr_wrap_first", 64'(queued), 64'(4'b0001));
    chk("rr_wrap_tag", 64'(cdb_tag), 64'(7'h05));
    cycle();
    chk("rr_wrap_second", 64'(queued), 64'(4'b0010));
    cycle();

    // Full with back-pressure: nine results, eight slots
    cdb_stall = 1'b1;
    issued = 0;
    for (int n = 0; n < 20; n++) begin
      random_issue(9, 100);
      cycle();
    end
    chk("full_flag", 64'(full), 64'(1));
    chk("full_count", 64'(count), 64'(8));
    chk("full_no_queued", 64'(queued), 64'(0));
    chk("full_ninth_waiting", 64'($countones(busy)), 64'(1));
    cdb_stall = 1'b0;
    cycle();
    chk("full_enq_on_deq", 64'(queued != 0), 64'(1));
    chk("full_count_hold", 64'(count), 64'(8));
    for (int n = 0; n < 40 && m_q.size() != 0; n++) cycle();
    chk("full_drained", 64'(count), 64'(0));

    // Stall hold with two entries
    cdb_stall = 1'b1;
    issue(0, 7'h0A, 32'hAAAA_0000);
    cycle();
    issue(1, 7'h0B, 32'hBBBB_0000);
    cycle();
    cycle();
    for (int n = 0; n < 3; n++) begin
      cycle();
      chk("stall_hold_tag", 64'(cdb_tag), 64'(7'h0A));
      chk("stall_hold_count", 64'(count), 64'(2));
    end
    cdb_stall = 1'b0;
    cycle();
    chk("stall_release_tag", 64'(cdb_tag), 64'(7'h0B));
    cycle();
    chk("stall_release_empty", 64'(cdb_valid), 64'(0));

    // Pointer wrap with random stalls
    next_tag = 0;
    issued = 0;
    for (int n = 0; n < 400 && (issued < 20 || busy != 0 || m_q.size() != 0); n++) begin
      cdb_stall = ($urandom_range(99) < 30);
      random_issue(20, 60);
      cycle();
    end
    cdb_stall = 1'b0;
    chk("wrap_completed", 64'(issued == 20 && busy == 0), 64'(1));
    chk("wrap_count_zero", 64'(count), 64'(0));

    // Mid-operation reset with five entries and FUs 1 and 3 pending
    cdb_stall = 1'b1;
    issued = 0;
    for (int n = 0; n < 60 && !(issued == 5 && busy == 0); n++) begin
      random_issue(5, 100);
      cycle();
    end
    chk("midrst_count5", 64'(count), 64'(5));
    issue(1, 7'h31, 32'h3131_3131);
    issue(3, 7'h33, 32'h3333_3333);
    cycle();
    rst = 1'b0;
    cycle();
    busy = '0;
    chk("midrst_valid", 64'(cdb_valid), 64'(0));
    chk("midrst_count", 64'(count), 64'(0));
    chk("midrst_full", 64'(full), 64'(0));
    chk("midrst_queued", 64'(queued), 64'(0));
    rst = 1'b1;
    cdb_stall = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cycle();
      chk("postrst_queued", 64'(queued), 64'(0));
      chk("postrst_valid", 64'(cdb_valid), 64'(0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
